// File: rtl/bcd_serial_adder_if.sv
// Operand/result handshake bundle for the serial BCD adder.
// The master side supplies the operands and consumes the result.
interface bcd_serial_adder_if #(
  parameter int NDIG = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [4*NDIG-1:0] a;
  logic [4*NDIG-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] sum;
  logic              carry_out;
  logic              err;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry_out, err
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry_out, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Packed-BCD adder that handles one digit per clock, least significant digit
// first, with the decimal carry kept in a register between digits.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// RUN    | adding digit idx, one digit per clock
// DONE   | result held, out_valid high until out_ready
module bcd_serial_adder #(
  parameter int NDIG = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_serial_adder_if.slave bus
);
  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            c_q, c_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  logic [3:0]      dig_a, dig_b, dig_r;
  logic [4:0]      t, t_adj;
  logic            c_nxt;
  logic            bad;

  always_comb begin
    dig_a = opa_q[4*int'(idx_q) +: 4];
    dig_b = opb_q[4*int'(idx_q) +: 4];
    t     = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, c_q};
    t_adj = t + 5'd6;
    bad   = (dig_a > 4'd9) || (dig_b > 4'd9);
    dig_r = t[3:0];
    c_nxt = 1'b0;
    // A non-decimal digit poisons only its own position and breaks the ripple.
    if (bad) begin
      dig_r = 4'd0;
      c_nxt = 1'b0;
    end else if (t > 5'd9) begin
      dig_r = t_adj[3:0];
      c_nxt = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    c_d     = c_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          sum_d   = '0;
          idx_d   = '0;
          c_d     = 1'b0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[4*int'(idx_q) +: 4] = dig_r;
        c_d = c_nxt;
        if (bad) err_d = 1'b1;
        if (idx_q == IW'(NDIG - 1)) begin
          cout_d  = c_nxt;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.err       = err_q;
endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Multi-digit packed-BCD adder for the calculator datapath; the additive counterpart of the per-digit BCD subtract unit.
- Processes one decimal digit per clock, least-significant digit first, with decimal carry ripple held in a register.
- Uses valid/ready handshakes on both input and output, so it sits between the operand registers and the display/result stage.

Parameters:
- NDIG, 4, number of BCD digits per operand (≥1); operand and result width is 4*NDIG.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset (sampled on rising clk).
- in_valid  in  1  operands a/b present.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  4*NDIG  packed BCD operand A; digit i = a[4i+3:4i].
- b  in  4*NDIG  packed BCD operand B, same packing.
- out_valid  out  1  result available (high only in DONE).
- out_ready  in  1  consumer accepts result.
- sum  out  4*NDIG  packed BCD result, registered.
- carry_out  out  1  decimal carry out of the most significant digit.
- err  out  1  sticky: at least one operand digit was greater than 9.

Behaviour:
- Reset (rst_n low at an edge):
  - state=IDLE; sum=0, carry_out=0, err=0, out_valid=0, in_ready=1 from the next cycle.
  - Internal digit index and carry are cleared.
  - Reset during RUN or DONE discards the operation.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); both decoded from state.
- IDLE:
  - On in_valid & in_ready: latch a and b into internal registers.
  - Clear sum, internal carry, err and the digit index (idx=0). Go to RUN.
  - Otherwise remain in IDLE; sum, carry_out and err hold their last values.
- RUN, one digit per cycle at position idx:
  - Compute t = a_d + b_d + c as a 5-bit value.
  - If a_d>9 or b_d>9: result digit = 0, next c = 0, err set to 1 (sticky until the next accept).
  - Else if t>9: result digit = (t+6)[3:0], i.e. t−10, and next c = 1.
  - Else: result digit = t[3:0] and next c = 0.
  - Write the result digit into sum[4idx+3:4idx].
  - If idx==NDIG-1: carry_out = next c; go to DONE. Otherwise idx++.
- Latency: operands accepted at edge k produce out_valid high after edge k+NDIG. Throughput is one operation per NDIG+2 cycles at best.
- DONE:
  - sum, carry_out and err are stable while out_valid=1.
  - On out_ready: go to IDLE; out_valid drops and in_ready rises in the next cycle.
  - No overlap: a new operation can never be accepted in the same cycle as result handoff.
- While not IDLE, in_valid, a and b are ignored. Operands latch only on accept, so later changes to a/b have no effect.
- The result is mod 10^NDIG; overflow is signalled solely by carry_out.
- out_ready outside DONE and in_valid outside IDLE have no effect.

Test Plan (NDIG=4):
- a=0x1234, b=0x4321, in_valid for 1 cycle:
  - in_ready drops the next cycle; out_valid rises exactly 4 cycles after the accept edge.
  - sum=0x5555, carry_out=0, err=0.
- a=0x9999, b=0x0001 → full carry ripple: sum=0x0000, carry_out=1, err=0.
- a=0x0958, b=0x0067 → sum=0x1025, carry_out=0. Also a=0x5000, b=0x5000 → sum=0x0000, carry_out=1.
- a=0x00A1, b=0x0001 → digit 0 = 2, digit 1 invalid forced to 0 with no carry: sum=0x0002, err=1, carry_out=0.
  - A following valid operation clears err to 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and toggle in_valid/a/b meanwhile.
  - sum, carry_out and out_valid stay stable; in_ready stays 0.
  - Then set out_ready=1 for 1 cycle → IDLE, and in_ready=1 on the next cycle.
- Drive rst_n=0 for 1 cycle after 2 RUN digits of 0x1234+0x4321:
  - Next cycle out_valid=0, sum=0, carry_out=0, err=0, in_ready=1.
  - A new operation then completes correctly.
